i2c_reg_bank: RTL and testbench

I2C_REG_BANK -- requirements
Module: i2c_reg_bank

---
 rtl/i2c_reg_bank.sv | 176 +++++++++++++++++
 tb/tb_i2c_reg_bank.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: pointer-addressed register bank for an I2C-style slave.
//
// An address pointer is loaded with addrLoad/addrIn and then advanced by
// every write or read strobe, so a host can stream through consecutive
// registers. Addresses 0..NUM_RW-1 are host-writable registers, and
// NUM_RW..NUM_RW+NUM_RO-1 are read-only status inputs.
//
// Optional feature (macro REG_BANK_LOCK_EN): a lock register at address
// TOTAL. Writing 8'hA5 locks out writes to the writable registers, and
// writing 8'h5A unlocks them. Reading that address returns {0.., locked}.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   domain          security-domain label, no functional effect
//   addrLoad/addrIn load the address pointer (takes priority over strobes)
//   wrStrobe        write dataIn at the pointer
//   rdStrobe        read the pointer into dataOut
//   dataIn          write data
//   dataOut         registered read data, held between reads
//   dataOutValid    one-cycle pulse when dataOut is updated
//   rwRegs          flattened writable registers, reg i at [i*DATA_W +: DATA_W]
//   roRegs          flattened read-only status inputs, same packing
//   wrPulse         one-hot pulse per completed register write
//   addrErr         one-cycle pulse on any rejected access
module i2c_reg_bank #(
  parameter int DATA_W = 8,
  parameter int NUM_RW = 4,
  parameter int NUM_RO = 4,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     domain,
  input  logic                     addrLoad,
  input  logic [ADDR_W-1:0]        addrIn,
  input  logic                     wrStrobe,
  input  logic                     rdStrobe,
  input  logic [DATA_W-1:0]        dataIn,
  output logic [DATA_W-1:0]        dataOut,
  output logic                     dataOutValid,
  output logic [NUM_RW*DATA_W-1:0] rwRegs,
  input  logic [NUM_RO*DATA_W-1:0] roRegs,
  output logic [NUM_RW-1:0]        wrPulse,
  output logic                     addrErr
);

  localparam int TOTAL = NUM_RW + NUM_RO;
  localparam logic [ADDR_W-1:0] RW_END  = ADDR_W'(NUM_RW);
  localparam logic [ADDR_W-1:0] TOTAL_A = ADDR_W'(TOTAL);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] rw_q [NUM_RW];
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dvld_q, dvld_d;
  logic [NUM_RW-1:0] wrp_q, wrp_d;
  logic              aerr_q, aerr_d;

  logic              in_rw, in_ro, is_lock, locked, lock_wr;
  logic [DATA_W-1:0] rd_val;
  logic              unused_domain;

  assign unused_domain = domain;

`ifdef REG_BANK_LOCK_EN
  // The lock register extends the valid address range by one.
  localparam logic [ADDR_W-1:0] LAST_A     = TOTAL_A;
  localparam logic [DATA_W-1:0] KEY_LOCK   = DATA_W'(8'hA5);
  localparam logic [DATA_W-1:0] KEY_UNLOCK = DATA_W'(8'h5A);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_e;
  lock_e lock_q, lock_d;

  assign is_lock = (ptr_q == TOTAL_A);

  always_ff @(posedge clk) begin
    if (rst) lock_q <= UNLOCKED;
    else     lock_q <= lock_d;
  end

  always_comb begin
    lock_d = lock_q;
    if (lock_wr) begin
      case (lock_q)
        UNLOCKED: if (dataIn == KEY_LOCK)   lock_d = LOCKED;
        LOCKED:   if (dataIn == KEY_UNLOCK) lock_d = UNLOCKED;
        default:  lock_d = UNLOCKED;
      endcase
    end
  end

  always_comb begin
    locked = (lock_q == LOCKED);
  end
`else
  localparam logic [ADDR_W-1:0] LAST_A = TOTAL_A - ADDR_W'(1);
  logic unused_lock_wr;
  assign is_lock        = 1'b0;
  assign locked         = 1'b0;
  assign unused_lock_wr = lock_wr;
`endif

  assign in_rw = (ptr_q < RW_END);
  assign in_ro = (ptr_q >= RW_END) && (ptr_q < TOTAL_A);

  // Read mux; out-of-range addresses fall through to zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_RW; i++)
      if (ptr_q == ADDR_W'(i)) rd_val = rw_q[i];
    for (int j = 0; j < NUM_RO; j++)
      if (ptr_q == ADDR_W'(NUM_RW + j)) rd_val = roRegs[j*DATA_W +: DATA_W];
    if (is_lock) rd_val = {{(DATA_W-1){1'b0}}, locked};
  end

  always_comb begin
    ptr_d   = ptr_q;
    dout_d  = dout_q;
    dvld_d  = 1'b0;
    wrp_d   = '0;
    aerr_d  = 1'b0;
    lock_wr = 1'b0;
    if (addrLoad) begin
      // Pointer load wins; strobes in the same cycle are dropped silently.
      ptr_d = addrIn;
    end else if (wrStrobe && rdStrobe) begin
      aerr_d = 1'b1;
    end else if (wrStrobe || rdStrobe) begin
      // Beyond the last valid address the pointer first steps out of
      // range, then returns to 0 on the following access.
      ptr_d = (ptr_q > LAST_A) ? '0 : ptr_q + ADDR_W'(1);
      if (wrStrobe) begin
        if (in_rw && !locked) begin
          for (int i = 0; i < NUM_RW; i++)
            if (ptr_q == ADDR_W'(i)) wrp_d[i] = 1'b1;
        end else if (is_lock) begin
          lock_wr = 1'b1;
        end else begin
          aerr_d = 1'b1;
        end
      end else begin
        dvld_d = 1'b1;
        dout_d = rd_val;
        if (!(in_rw || in_ro || is_lock)) aerr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      dout_q <= '0;
      dvld_q <= 1'b0;
      wrp_q  <= '0;
      aerr_q <= 1'b0;
      for (int i = 0; i < NUM_RW; i++) rw_q[i] <= '0;
    end else begin
      ptr_q  <= ptr_d;
      dout_q <= dout_d;
      dvld_q <= dvld_d;
      wrp_q  <= wrp_d;
      aerr_q <= aerr_d;
      for (int i = 0; i < NUM_RW; i++)
        if (wrp_d[i]) rw_q[i] <= dataIn;
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_flat
    assign rwRegs[g*DATA_W +: DATA_W] = rw_q[g];
  end

  assign dataOut      = dout_q;
  assign dataOutValid = dvld_q;
  assign wrPulse      = wrp_q;
  assign addrErr      = aerr_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Self-checking bench for i2c_reg_bank: directed scenarios plus a short
// random phase, with read data checked through an expected-value queue.
module tb_i2c_reg_bank;
  localparam int DATA_W = 8;
  localparam int NUM_RW = 4;
  localparam int NUM_RO = 4;
  localparam int ADDR_W = 8;
  localparam int TOTAL  = NUM_RW + NUM_RO;
`ifdef REG_BANK_LOCK_EN
  localparam int  LAST    = TOTAL;
  localparam bit  LOCK_EN = 1'b1;
`else
  localparam int  LAST    = TOTAL - 1;
  localparam bit  LOCK_EN = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     domain;
  logic                     addrLoad;
  logic [ADDR_W-1:0]        addrIn;
  logic                     wrStrobe;
  logic                     rdStrobe;
  logic [DATA_W-1:0]        dataIn;
  logic [DATA_W-1:0]        dataOut;
  logic                     dataOutValid;
  logic [NUM_RW*DATA_W-1:0] rwRegs;
  logic [NUM_RO*DATA_W-1:0] roRegs;
  logic [NUM_RW-1:0]        wrPulse;
  logic                     addrErr;

  i2c_reg_bank #(.DATA_W(DATA_W), .NUM_RW(NUM_RW), .NUM_RO(NUM_RO), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .domain(domain), .addrLoad(addrLoad), .addrIn(addrIn),
    .wrStrobe(wrStrobe), .rdStrobe(rdStrobe), .dataIn(dataIn), .dataOut(dataOut),
    .dataOutValid(dataOutValid), .rwRegs(rwRegs), .roRegs(roRegs), .wrPulse(wrPulse),
    .addrErr(addrErr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] sb_e;
  logic [DATA_W-1:0] m_rw [NUM_RW];
  logic [DATA_W-1:0] m_dout;
  int                m_ptr;
  bit                m_locked;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every dataOutValid pops one expected read value.
  always @(negedge clk) begin
    if (dataOutValid) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected_valid", 1, 0);
      end else begin
        sb_e = exp_q.pop_front();
        check_val("sb_dataOut", dataOut, sb_e);
      end
    end
  end

  function automatic logic [NUM_RW*DATA_W-1:0] m_flat();
    logic [NUM_RW*DATA_W-1:0] f;
    for (int i = 0; i < NUM_RW; i++) f[i*DATA_W +: DATA_W] = m_rw[i];
    return f;
  endfunction

  function automatic bit m_in_range(input int p);
    return (p < TOTAL) || (LOCK_EN && p == TOTAL);
  endfunction

  function automatic logic [DATA_W-1:0] m_val(input int p);
    if (p < NUM_RW) return m_rw[p];
    if (p < TOTAL)  return roRegs[(p-NUM_RW)*DATA_W +: DATA_W];
    if (LOCK_EN && p == TOTAL) return {{(DATA_W-1){1'b0}}, m_locked};
    return '0;
  endfunction

  function automatic int m_next(input int p);
    return (p > LAST) ? 0 : p + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int a);
    addrLoad = 1'b1;
    addrIn   = ADDR_W'(a);
    step();
    addrLoad = 1'b0;
    m_ptr    = a;
    check_val("load_addrErr", addrErr, 0);
    check_val("load_wrPulse", wrPulse, 0);
  endtask

  task automatic do_write(input logic [DATA_W-1:0] d);
    bit ok, lockw;
    logic [NUM_RW-1:0] ewp;
    ok    = (m_ptr < NUM_RW) && !m_locked;
    lockw = LOCK_EN && (m_ptr == TOTAL);
    ewp   = ok ? NUM_RW'(1 << m_ptr) : '0;
    wrStrobe = 1'b1;
    dataIn   = d;
    step();
    wrStrobe = 1'b0;
    if (ok) m_rw[m_ptr] = d;
    if (lockw && d == 8'hA5) m_locked = 1'b1;
    if (lockw && d == 8'h5A) m_locked = 1'b0;
    check_val("wr_wrPulse", wrPulse, ewp);
    check_val("wr_addrErr", addrErr, !(ok || lockw));
    check_val("wr_rwRegs", rwRegs, m_flat());
    m_ptr = m_next(m_ptr);
  endtask

  task automatic do_read();
    logic [DATA_W-1:0] e;
    e = m_val(m_ptr);
    exp_q.push_back(e);
    rdStrobe = 1'b1;
    step();
    rdStrobe = 1'b0;
    m_dout = e;
    check_val("rd_valid", dataOutValid, 1);
    check_val("rd_addrErr", addrErr, !m_in_range(m_ptr));
    m_ptr = m_next(m_ptr);
  endtask

  task automatic do_idle();
    step();
    check_val("idle_valid", dataOutValid, 0);
    check_val("idle_hold", dataOut, m_dout);
    check_val("idle_addrErr", addrErr, 0);
    check_val("idle_wrPulse", wrPulse, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_RW; i++) m_rw[i] = '0;
    m_ptr = 0; m_dout = '0; m_locked = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; domain = 1'b0; addrLoad = 1'b0; addrIn = '0;
    wrStrobe = 1'b0; rdStrobe = 1'b0; dataIn = '0;
    roRegs = 32'hDDCCBBAA;
    model_reset();
    repeat (3) step();
    check_val("rst_dataOut", dataOut, 0);
    check_val("rst_valid", dataOutValid, 0);
    check_val("rst_wrPulse", wrPulse, 0);
    check_val("rst_addrErr", addrErr, 0);
    check_val("rst_rwRegs", rwRegs, 0);
    rst = 1'b0;
    do_idle();

    // Back-to-back writes from address 0, then the pointer sits at 4.
    do_load(0);
    do_write(8'h11); do_write(8'h22); do_write(8'h33); do_write(8'h44);
    check_val("seq_rwRegs", rwRegs, 32'h44332211);
    do_read();                       // address 4 -> AA
    do_idle();

    // Stream through the status inputs and past the end.
    do_load(4);
    repeat (6) do_read();            // AA BB CC DD, out of range (err), then reg 0
    do_idle();

    // Simultaneous write and read strobes are rejected; pointer stays.
    do_load(2);
    wrStrobe = 1'b1; rdStrobe = 1'b1; dataIn = 8'h99;
    step();
    wrStrobe = 1'b0; rdStrobe = 1'b0;
    check_val("both_addrErr", addrErr, 1);
    check_val("both_valid", dataOutValid, 0);
    check_val("both_wrPulse", wrPulse, 0);
    check_val("both_rwRegs", rwRegs, m_flat());
    do_read();                       // still address 2 -> 33

    // Write to a read-only address is rejected but advances the pointer.
    do_load(5);
    do_write(8'hEE);
    do_read();                       // address 6 -> CC

    // Pointer load overrides a strobe in the same cycle.
    addrLoad = 1'b1; addrIn = 8'd1; wrStrobe = 1'b1; dataIn = 8'h66;
    step();
    addrLoad = 1'b0; wrStrobe = 1'b0; m_ptr = 1;
    check_val("ldpri_addrErr", addrErr, 0);
    check_val("ldpri_wrPulse", wrPulse, 0);
    do_read();                       // address 1 -> 22
    do_idle();

    // Out-of-range write, then the pointer returns to 0.
    do_load(12);
    do_write(8'h5C);
    do_write(8'h0F);

`ifdef REG_BANK_LOCK_EN
    do_load(TOTAL); do_write(8'hA5);
    do_load(0);     do_write(8'h77); // rejected while locked
    do_load(TOTAL); do_read();       // 01
    do_load(TOTAL); do_write(8'h3C); // no state change
    do_load(TOTAL); do_write(8'h5A);
    do_load(0);     do_write(8'h77);
    do_load(TOTAL); do_read();       // 00
`endif

    // Reset arriving with a write discards the write.
    do_load(0);
    do_write(8'hA1); do_write(8'hA2); do_write(8'hA3);
    rst = 1'b1; wrStrobe = 1'b1; dataIn = 8'hF0;
    step();
    rst = 1'b0; wrStrobe = 1'b0;
    model_reset();
    check_val("rstwr_rwRegs", rwRegs, 0);
    check_val("rstwr_wrPulse", wrPulse, 0);
    check_val("rstwr_dataOut", dataOut, 0);
    check_val("rstwr_addrErr", addrErr, 0);
    do_idle();
    do_load(0);
    do_read();                       // 00

    // Random traffic against the model.
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0: do_load($urandom_range(0, 11));
        1: do_write(DATA_W'($urandom_range(0, 255)));
        2: do_read();
        default: do_idle();
      endcase
    end

    repeat (2) step();
    check_val("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
